// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-facing memory path: RAM status, arbiter states, defaults.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        ERRST = 2'd3
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of datapath-side requests/responses and RAM-side strobes around memory_arbiter.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              iREN, dREN, dWEN;
    logic [ADDR_W-1:0] iaddr, daddr;
    logic [WORD_W-1:0] dstore;
    logic              iwait, dwait;
    logic [WORD_W-1:0] iload, dload;
    logic              ramREN, ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore, ramload;
    logic [1:0]        ramstate;
    logic              err;

    modport dp  (output iREN, dREN, dWEN, iaddr, daddr, dstore,
                 input  iwait, dwait, iload, dload, err);
    modport ram (input  ramREN, ramWEN, ramaddr, ramstore,
                 output ramload, ramstate);
endinterface

// File: rtl/arb_timeout_counter.sv
// Per-transaction watchdog: counts non-ACCESS cycles; o_tc flags the cycle the count reaches TIMEOUT.
module arb_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [7:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)      r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + 8'd1;
    end

    // Terminal on the increment that would make the count equal TIMEOUT.
    assign o_tc = i_en && (r_cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/memory_arbiter.sv
// Serializes instruction fetches and data loads/stores onto a single-ported RAM, data first.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);
    arb_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_store, r_iload, r_dload;
    logic              r_wr;
    logic              w_busy, w_iwait, w_dwait, w_tc, w_clr, w_en;
    ramstate_t         w_rs;

    assign w_rs   = ramstate_t'(ramstate);
    assign w_busy = (r_state == DATA) || (r_state == INSTR);
    assign w_en   = w_busy && (w_rs != ACCESS);
    assign w_clr  = !w_busy || (w_next != r_state);

    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .CLK  (CLK),
        .nRST (nRST),
        .i_clr(w_clr),
        .i_en (w_en),
        .o_tc (w_tc)
    );

    always_comb begin
        w_next  = r_state;
        w_iwait = 1'b1;
        w_dwait = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (dREN || dWEN) w_next = DATA;
                else if (iREN)    w_next = INSTR;
            end
            DATA: begin
                if (w_rs == ACCESS) begin
                    w_next  = IDLE;
                    w_dwait = 1'b0;
                end
                else if (w_rs == ERROR)  w_next = ERRST;
                else if (!(dREN || dWEN)) w_next = IDLE;
                else if (w_tc)           w_next = ERRST;
            end
            INSTR: begin
                if (w_rs == ACCESS) begin
                    w_next  = IDLE;
                    w_iwait = 1'b0;
                end
                else if (w_rs == ERROR) w_next = ERRST;
                else if (!iREN)         w_next = IDLE;
                else if (w_tc)          w_next = ERRST;
            end
            default: w_next = ERRST;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_store <= '0;
            r_wr    <= 1'b0;
            r_iload <= '0;
            r_dload <= '0;
        end else begin
            r_state <= w_next;
            // Capture the request only on the IDLE exit edge; later address changes are ignored.
            if (r_state == IDLE) begin
                if (dREN || dWEN) begin
                    r_addr  <= daddr;
                    r_store <= dstore;
                    r_wr    <= dWEN;
                end else if (iREN) begin
                    r_addr  <= iaddr;
                    r_store <= '0;
                    r_wr    <= 1'b0;
                end
            end
            if (!w_iwait) r_iload <= ramload;
            if (!w_dwait) r_dload <= ramload;
        end
    end

    assign iwait    = w_iwait;
    assign dwait    = w_dwait;
    assign iload    = w_iwait ? r_iload : ramload;
    assign dload    = w_dwait ? r_dload : ramload;
    assign ramREN   = w_busy && !r_wr;
    assign ramWEN   = w_busy && r_wr;
    assign ramaddr  = w_busy ? r_addr : '0;
    assign ramstore = w_busy ? r_store : '0;
    assign err      = (r_state == ERRST);
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter built with TIMEOUT=4.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_chk = 0;
    int n_err = 0;

    memory_arbiter #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to 2 time units after the next rising edge; inputs change and checks happen here.
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #12;
        chk("rst_iwait", iwait, 1);   chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 0);   chk("rst_dload", dload, 0);
        chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
        chk("rst_err", err, 0);
        nRST = 1'b1;
        cyc();

        // Instruction fetch, ACCESS on the 2nd cycle
        iREN = 1; iaddr = 32'h40;
        #1 chk("if_c1_iwait", iwait, 1); chk("if_c1_ramREN", ramREN, 0);
        cyc();
        ramstate = ACCESS; ramload = 32'h2401_0005;
        #1 chk("if_ramREN", ramREN, 1); chk("if_ramWEN", ramWEN, 0);
        chk("if_ramaddr", ramaddr, 32'h40); chk("if_iwait", iwait, 0);
        chk("if_iload", iload, 32'h2401_0005); chk("if_dwait", dwait, 1);
        cyc();
        iREN = 0; ramstate = FREE; ramload = 32'h0;
        #1 chk("if_after_iwait", iwait, 1); chk("if_after_ramREN", ramREN, 0);
        chk("if_iload_hold", iload, 32'h2401_0005);

        // Simultaneous instr + data write: data wins, then one IDLE cycle, then fetch
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        cyc();
        ramstate = ACCESS;
        #1 chk("pr_ramWEN", ramWEN, 1); chk("pr_ramREN", ramREN, 0);
        chk("pr_ramaddr", ramaddr, 32'h100); chk("pr_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("pr_dwait", dwait, 0); chk("pr_iwait", iwait, 1);
        cyc();
        dWEN = 0; ramstate = FREE;
        #1 chk("pr_idle_ramWEN", ramWEN, 0); chk("pr_idle_ramREN", ramREN, 0);
        chk("pr_idle_dwait", dwait, 1);
        cyc();
        ramstate = ACCESS; ramload = 32'h0000_AAAA;
        #1 chk("pr_if_ramREN", ramREN, 1); chk("pr_if_ramaddr", ramaddr, 32'h44);
        chk("pr_if_iwait", iwait, 0); chk("pr_if_iload", iload, 32'h0000_AAAA);
        cyc();
        iREN = 0; ramstate = FREE;

        // Data read with 3 BUSY cycles, address change ignored mid-transaction
        dREN = 1; daddr = 32'h200;
        #1 chk("rd_c1_dwait", dwait, 1);
        cyc();
        ramstate = BUSY;
        #1 chk("rd_ramREN", ramREN, 1); chk("rd_ramaddr", ramaddr, 32'h200);
        chk("rd_c2_dwait", dwait, 1);
        cyc();
        daddr = 32'h300;
        #1 chk("rd_addr_latched", ramaddr, 32'h200); chk("rd_c3_dwait", dwait, 1);
        cyc();
        #1 chk("rd_c4_dwait", dwait, 1);
        cyc();
        ramstate = ACCESS; ramload = 32'h1234;
        #1 chk("rd_c5_dwait", dwait, 0); chk("rd_dload", dload, 32'h1234);
        cyc();
        dREN = 0; ramstate = FREE; ramload = 32'h5555;
        #1 chk("rd_after_dwait", dwait, 1); chk("rd_dload_hold", dload, 32'h1234);
        chk("rd_after_err", err, 0);

        // Abort: dREN drops one cycle into DATA
        dREN = 1; daddr = 32'h80;
        cyc();
        ramstate = BUSY;
        #1 chk("ab_ramREN_on", ramREN, 1);
        dREN = 0;
        #1 chk("ab_ramREN_hold", ramREN, 1); chk("ab_dwait", dwait, 1);
        cyc();
        #1 chk("ab_ramREN_drop", ramREN, 0); chk("ab_dwait2", dwait, 1);
        chk("ab_err", err, 0);
        iREN = 1; iaddr = 32'h60; ramstate = FREE;
        cyc();
        ramstate = ACCESS; ramload = 32'h77;
        #1 chk("ab_if_ramaddr", ramaddr, 32'h60); chk("ab_if_iwait", iwait, 0);
        chk("ab_if_iload", iload, 32'h77);
        cyc();
        iREN = 0; ramstate = FREE;

        // Asynchronous reset mid-DATA
        dWEN = 1; daddr = 32'h10; dstore = 32'h99;
        cyc();
        ramstate = BUSY;
        #1 chk("ar_ramWEN_on", ramWEN, 1);
        #1 nRST = 1'b0;
        #1 chk("ar_ramWEN", ramWEN, 0); chk("ar_ramREN", ramREN, 0);
        chk("ar_iwait", iwait, 1); chk("ar_dwait", dwait, 1);
        chk("ar_ramaddr", ramaddr, 0); chk("ar_dload", dload, 0);
        chk("ar_iload", iload, 0);
        dWEN = 0; ramstate = FREE;
        cyc();
        nRST = 1'b1;
        cyc();
        #1 chk("ar_post_ramREN", ramREN, 0); chk("ar_post_ramWEN", ramWEN, 0);

        // Timeout: BUSY held with TIMEOUT=4
        dREN = 1; daddr = 32'h20;
        cyc();
        ramstate = BUSY;
        #1 chk("to_b1_ramREN", ramREN, 1);
        cyc(); cyc(); cyc();
        #1 chk("to_b4_ramREN", ramREN, 1); chk("to_b4_err", err, 0);
        cyc();
        #1 chk("to_err", err, 1); chk("to_ramREN", ramREN, 0);
        chk("to_ramWEN", ramWEN, 0); chk("to_iwait", iwait, 1); chk("to_dwait", dwait, 1);
        dREN = 0; iREN = 1; iaddr = 32'h88; ramstate = ACCESS; ramload = 32'h4242;
        cyc(); cyc();
        #1 chk("to_sticky_err", err, 1); chk("to_ign_iwait", iwait, 1);
        chk("to_ign_ramREN", ramREN, 0);
        nRST = 1'b0;
        #1 chk("to_rst_err", err, 0);
        #1 nRST = 1'b1;
        cyc();
        #1 chk("to_rec_ramREN", ramREN, 1); chk("to_rec_ramaddr", ramaddr, 32'h88);
        chk("to_rec_iwait", iwait, 0); chk("to_rec_iload", iload, 32'h4242);
        chk("to_rec_err", err, 0);
        cyc();
        iREN = 0; ramstate = FREE;

        // ERROR status from RAM goes straight to ERRST
        dREN = 1; daddr = 32'h30;
        cyc();
        ramstate = ERROR;
        #1 chk("re_dwait", dwait, 1);
        cyc();
        #1 chk("re_err", err, 1); chk("re_ramREN", ramREN, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
